// File: rtl/pifo_sched_gen.sv
// pifo_sched_gen: rank-sorted push-in-first-out scheduler with one push and
// one pop per cycle. Entry 0 holds the lowest rank; equal ranks keep arrival
// order. With PUSHOUT=1 a push into a full array evicts the worst element.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   push_valid/ready/rank/value  push handshake and element
//   pop_ready/valid/rank/value   pop handshake, head element (entry 0)
//   count                        current occupancy
//   evict_valid/rank/value       one-cycle report of a discarded element
module pifo_sched_gen #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned RANK_W  = 16,
   parameter int unsigned VALUE_W = 32,
   parameter int unsigned PUSHOUT = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_valid,
   output logic                         push_ready,
   input  logic [RANK_W-1:0]            push_rank,
   input  logic [VALUE_W-1:0]           push_value,
   input  logic                         pop_ready,
   output logic                         pop_valid,
   output logic [RANK_W-1:0]            pop_rank,
   output logic [VALUE_W-1:0]           pop_value,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         evict_valid,
   output logic [RANK_W-1:0]            evict_rank,
   output logic [VALUE_W-1:0]           evict_value
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [RANK_W-1:0]  rank_q  [DEPTH];
   logic [VALUE_W-1:0] value_q [DEPTH];
   logic [CW-1:0]      count_q;

   logic [RANK_W-1:0]  rank_d  [DEPTH];
   logic [VALUE_W-1:0] value_d [DEPTH];
   logic [CW-1:0]      count_d;

   // base = array after an optional pop, padded with one spare slot
   logic [RANK_W-1:0]  base_rank  [DEPTH+1];
   logic [VALUE_W-1:0] base_value [DEPTH+1];
   // ext = base with the pushed element inserted (DEPTH+1 entries)
   logic [RANK_W-1:0]  ext_rank   [DEPTH+1];
   logic [VALUE_W-1:0] ext_value  [DEPTH+1];

   logic [CW-1:0]      pos;
   logic [CW-1:0]      base_pos;
   logic               full;
   logic               push_fire;
   logic               pop_fire;
   logic               evict_c;
   logic [RANK_W-1:0]  evict_rank_c;
   logic [VALUE_W-1:0] evict_value_c;

   // Head is served straight from entry 0; no path from the push inputs.
   assign pop_valid = (count_q != '0);
   assign pop_rank  = rank_q[0];
   assign pop_value = value_q[0];
   assign count     = count_q;
   assign full      = (count_q == CW'(DEPTH));

   generate
      if (PUSHOUT != 0) begin : g_pushout
         assign push_ready = 1'b1;
      end else begin : g_stall
         // a pop in the same cycle frees a slot even when full
         assign push_ready = !full || pop_ready;
      end
   endgenerate

   assign push_fire = push_valid && push_ready;
   assign pop_fire  = pop_valid && pop_ready;

   // Next-state array: insert position taken against the pre-pop array.
   always_comb begin
      pos = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if ((CW'(i) < count_q) && (rank_q[i] <= push_rank)) begin
            pos = pos + CW'(1);
         end
      end

      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
         base_rank[i]  = pop_fire ? rank_q[i+1]  : rank_q[i];
         base_value[i] = pop_fire ? value_q[i+1] : value_q[i];
      end
      base_rank[DEPTH-1]  = pop_fire ? '0 : rank_q[DEPTH-1];
      base_value[DEPTH-1] = pop_fire ? '0 : value_q[DEPTH-1];
      base_rank[DEPTH]    = '0;
      base_value[DEPTH]   = '0;

      // the popped old head occupied one of the pos slots unless pos == 0
      base_pos = (pop_fire && (pos != '0)) ? pos - CW'(1) : pos;

      ext_rank[0]  = (base_pos == '0) ? push_rank  : base_rank[0];
      ext_value[0] = (base_pos == '0) ? push_value : base_value[0];
      for (int j = 1; j <= int'(DEPTH); j++) begin
         if (CW'(j) < base_pos) begin
            ext_rank[j]  = base_rank[j];
            ext_value[j] = base_value[j];
         end else if (CW'(j) == base_pos) begin
            ext_rank[j]  = push_rank;
            ext_value[j] = push_value;
         end else begin
            ext_rank[j]  = base_rank[j-1];
            ext_value[j] = base_value[j-1];
         end
      end

      rank_d        = rank_q;
      value_d       = value_q;
      count_d       = count_q;
      evict_c       = 1'b0;
      evict_rank_c  = '0;
      evict_value_c = '0;

      if (push_fire && full && !pop_fire) begin
         // only reachable with PUSHOUT: keep the DEPTH best, drop the worst
         evict_c = 1'b1;
         if (pos < CW'(DEPTH)) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
               rank_d[i]  = ext_rank[i];
               value_d[i] = ext_value[i];
            end
            evict_rank_c  = ext_rank[DEPTH];
            evict_value_c = ext_value[DEPTH];
         end else begin
            evict_rank_c  = push_rank;
            evict_value_c = push_value;
         end
      end else if (push_fire) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            rank_d[i]  = ext_rank[i];
            value_d[i] = ext_value[i];
         end
         if (!pop_fire) begin
            count_d = count_q + CW'(1);
         end
      end else if (pop_fire) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            rank_d[i]  = base_rank[i];
            value_d[i] = base_value[i];
         end
         count_d = count_q - CW'(1);
      end
   end

   // State and eviction report registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            rank_q[i]  <= '0;
            value_q[i] <= '0;
         end
         count_q     <= '0;
         evict_valid <= 1'b0;
         evict_rank  <= '0;
         evict_value <= '0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            rank_q[i]  <= rank_d[i];
            value_q[i] <= value_d[i];
         end
         count_q     <= count_d;
         evict_valid <= evict_c;
         if (evict_c) begin
            evict_rank  <= evict_rank_c;
            evict_value <= evict_value_c;
         end
      end
   end

endmodule

// File: tb/tb_pifo_sched_gen.sv
// Directed bench for pifo_sched_gen: a stalling and a push-out instance,
// both DEPTH=4, driven from a vector table plus an asynchronous-reset sequence.
module tb_pifo_sched_gen;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned RW    = 8;
   localparam int unsigned VW    = 16;
   localparam int unsigned CW    = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // stalling instance
   logic          s_push_valid, s_push_ready, s_pop_ready, s_pop_valid;
   logic [RW-1:0] s_push_rank, s_pop_rank, s_evict_rank;
   logic [VW-1:0] s_push_value, s_pop_value, s_evict_value;
   logic [CW-1:0] s_count;
   logic          s_evict_valid;
   // push-out instance
   logic          p_push_valid, p_push_ready, p_pop_ready, p_pop_valid;
   logic [RW-1:0] p_push_rank, p_pop_rank, p_evict_rank;
   logic [VW-1:0] p_push_value, p_pop_value, p_evict_value;
   logic [CW-1:0] p_count;
   logic          p_evict_valid;

   pifo_sched_gen #(.DEPTH(DEPTH), .RANK_W(RW), .VALUE_W(VW), .PUSHOUT(0)) u_stall (
      .clk(clk), .rst(rst),
      .push_valid(s_push_valid), .push_ready(s_push_ready),
      .push_rank(s_push_rank), .push_value(s_push_value),
      .pop_ready(s_pop_ready), .pop_valid(s_pop_valid),
      .pop_rank(s_pop_rank), .pop_value(s_pop_value), .count(s_count),
      .evict_valid(s_evict_valid), .evict_rank(s_evict_rank), .evict_value(s_evict_value)
   );

   pifo_sched_gen #(.DEPTH(DEPTH), .RANK_W(RW), .VALUE_W(VW), .PUSHOUT(1)) u_pushout (
      .clk(clk), .rst(rst),
      .push_valid(p_push_valid), .push_ready(p_push_ready),
      .push_rank(p_push_rank), .push_value(p_push_value),
      .pop_ready(p_pop_ready), .pop_valid(p_pop_valid),
      .pop_rank(p_pop_rank), .pop_value(p_pop_value), .count(p_count),
      .evict_valid(p_evict_valid), .evict_rank(p_evict_rank), .evict_value(p_evict_value)
   );

   typedef struct {
      bit            dut;      // 0 = stalling, 1 = push-out
      logic          pv;
      logic [RW-1:0] rank;
      logic [VW-1:0] val;
      logic          popr;
      logic          e_prdy;   // push_ready before the edge
      logic          e_pv;     // head state after the edge
      logic [RW-1:0] e_rank;
      logic [VW-1:0] e_val;
      logic [CW-1:0] e_cnt;
      logic          e_ev;
      logic [RW-1:0] e_erank;
      logic [VW-1:0] e_eval;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(bit d, logic pv, logic [RW-1:0] r, logic [VW-1:0] v, logic popr,
                               logic eprdy, logic epv, logic [RW-1:0] er, logic [VW-1:0] ev,
                               logic [CW-1:0] ec, logic eev, logic [RW-1:0] eer,
                               logic [VW-1:0] eev_val);
      vec_t t;
      t.dut = d; t.pv = pv; t.rank = r; t.val = v; t.popr = popr;
      t.e_prdy = eprdy; t.e_pv = epv; t.e_rank = er; t.e_val = ev; t.e_cnt = ec;
      t.e_ev = eev; t.e_erank = eer; t.e_eval = eev_val;
      return t;
   endfunction

   task automatic chk(input string what, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", what, got, exp);
      end
   endtask

   task automatic idle_inputs();
      s_push_valid = 1'b0; s_push_rank = '0; s_push_value = '0; s_pop_ready = 1'b0;
      p_push_valid = 1'b0; p_push_rank = '0; p_push_value = '0; p_pop_ready = 1'b0;
   endtask

   task automatic apply(input int idx, input vec_t v);
      logic          prdy, pv, ev;
      logic [RW-1:0] pr, er;
      logic [VW-1:0] pval, eval;
      logic [CW-1:0] cnt;
      @(negedge clk);
      if (v.dut) begin
         p_push_valid = v.pv; p_push_rank = v.rank; p_push_value = v.val; p_pop_ready = v.popr;
      end else begin
         s_push_valid = v.pv; s_push_rank = v.rank; s_push_value = v.val; s_pop_ready = v.popr;
      end
      #1;
      prdy = v.dut ? p_push_ready : s_push_ready;
      chk($sformatf("row%0d push_ready", idx), 32'(prdy), 32'(v.e_prdy));
      @(posedge clk);
      #1;
      idle_inputs();
      pv   = v.dut ? p_pop_valid   : s_pop_valid;
      pr   = v.dut ? p_pop_rank    : s_pop_rank;
      pval = v.dut ? p_pop_value   : s_pop_value;
      cnt  = v.dut ? p_count       : s_count;
      ev   = v.dut ? p_evict_valid : s_evict_valid;
      er   = v.dut ? p_evict_rank  : s_evict_rank;
      eval = v.dut ? p_evict_value : s_evict_value;
      chk($sformatf("row%0d count", idx), 32'(cnt), 32'(v.e_cnt));
      chk($sformatf("row%0d pop_valid", idx), 32'(pv), 32'(v.e_pv));
      if (v.e_pv) begin
         chk($sformatf("row%0d pop_rank", idx), 32'(pr), 32'(v.e_rank));
         chk($sformatf("row%0d pop_value", idx), 32'(pval), 32'(v.e_val));
      end
      chk($sformatf("row%0d evict_valid", idx), 32'(ev), 32'(v.e_ev));
      if (v.e_ev) begin
         chk($sformatf("row%0d evict_rank", idx), 32'(er), 32'(v.e_erank));
         chk($sformatf("row%0d evict_value", idx), 32'(eval), 32'(v.e_eval));
      end
   endtask

   initial begin
      // ordering with FIFO tie-break: 5A,2B,9C,2D -> B,D,A,C
      tbl.push_back(mk(0, 1, 5, 16'h000A, 0, 1, 1, 5, 16'h000A, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2, 16'h000B, 0, 1, 1, 2, 16'h000B, 2, 0, 0, 0));
      tbl.push_back(mk(0, 1, 9, 16'h000C, 0, 1, 1, 2, 16'h000B, 3, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2, 16'h000D, 0, 1, 1, 2, 16'h000B, 4, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 1, 2, 16'h000D, 3, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 1, 5, 16'h000A, 2, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 1, 9, 16'h000C, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
      // push into empty with pop_ready: no bypass
      tbl.push_back(mk(0, 1, 7, 16'h0077, 1, 1, 1, 7, 16'h0077, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
      // {3,8}: push 1 with pop -> 3 leaves, array {1,8}
      tbl.push_back(mk(0, 1, 3, 16'h0033, 0, 1, 1, 3, 16'h0033, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 8, 16'h0088, 0, 1, 1, 3, 16'h0033, 2, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 16'h0011, 1, 1, 1, 1, 16'h0011, 2, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 1, 8, 16'h0088, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
      // stalling full {1,2,3,4}
      tbl.push_back(mk(0, 1, 1, 16'h0101, 0, 1, 1, 1, 16'h0101, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2, 16'h0102, 0, 1, 1, 1, 16'h0101, 2, 0, 0, 0));
      tbl.push_back(mk(0, 1, 3, 16'h0103, 0, 1, 1, 1, 16'h0101, 3, 0, 0, 0));
      tbl.push_back(mk(0, 1, 4, 16'h0104, 0, 1, 1, 1, 16'h0101, 4, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 16'h00F0, 0, 0, 1, 1, 16'h0101, 4, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 16'h00F0, 1, 1, 1, 0, 16'h00F0, 4, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 1, 2, 16'h0102, 3, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 1, 3, 16'h0103, 2, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 1, 4, 16'h0104, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
      // push-out full {1,2,3,4}
      tbl.push_back(mk(1, 1, 1, 16'h0201, 0, 1, 1, 1, 16'h0201, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2, 16'h0202, 0, 1, 1, 1, 16'h0201, 2, 0, 0, 0));
      tbl.push_back(mk(1, 1, 3, 16'h0203, 0, 1, 1, 1, 16'h0201, 3, 0, 0, 0));
      tbl.push_back(mk(1, 1, 4, 16'h0204, 0, 1, 1, 1, 16'h0201, 4, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2, 16'h00AA, 0, 1, 1, 1, 16'h0201, 4, 1, 4, 16'h0204));
      tbl.push_back(mk(1, 1, 9, 16'h00BB, 0, 1, 1, 1, 16'h0201, 4, 1, 9, 16'h00BB));
      tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h0201, 4, 0, 0, 0));
      // full with pop: plain push+pop, array becomes {0,2,2X,3}
      tbl.push_back(mk(1, 1, 0, 16'h00CC, 1, 1, 1, 0, 16'h00CC, 4, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 2, 16'h0202, 3, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 2, 16'h00AA, 2, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 3, 16'h0203, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
      // fill for the asynchronous reset sequence
      tbl.push_back(mk(0, 1, 10, 16'h1010, 0, 1, 1, 10, 16'h1010, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 11, 16'h1111, 0, 1, 1, 10, 16'h1010, 2, 0, 0, 0));
      tbl.push_back(mk(0, 1, 12, 16'h1212, 0, 1, 1, 10, 16'h1010, 3, 0, 0, 0));

      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      chk("reset s_count", 32'(s_count), 32'd0);
      chk("reset s_pop_valid", 32'(s_pop_valid), 32'd0);
      chk("reset p_evict_valid", 32'(p_evict_valid), 32'd0);
      chk("reset p_evict_rank", 32'(p_evict_rank), 32'd0);
      chk("reset p_evict_value", 32'(p_evict_value), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(i, tbl[i]);
      end

      // asynchronous reset between edges with three entries held
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst count", 32'(s_count), 32'd0);
      chk("arst pop_valid", 32'(s_pop_valid), 32'd0);
      s_push_valid = 1'b1; s_push_rank = 8'd6; s_push_value = 16'h0606;
      @(posedge clk);
      #1;
      chk("push during reset count", 32'(s_count), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      idle_inputs();
      chk("post-reset pop_valid", 32'(s_pop_valid), 32'd1);
      chk("post-reset pop_rank", 32'(s_pop_rank), 32'd6);
      chk("post-reset pop_value", 32'(s_pop_value), 32'h0606);
      chk("post-reset count", 32'(s_count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pifo_sched_gen.md
Name: pifo_sched_gen

Overview:
- Parametrised push-in-first-out (PIFO) scheduler: one push and one pop per cycle, each on its own valid/ready handshake.
- Holds up to DEPTH entries in a rank-sorted register array. Entry 0 is the lowest rank; ties resolve FIFO.
- Adds what the previous flow scheduler lacked: configurable rank/value widths, correct same-cycle push+pop (including when full), an occupancy count, and an optional push-out mode that evicts the worst entry instead of stalling.
- Sits between the rank computation stage and the egress port arbiter.

Parameters:
- DEPTH, 16, number of entries; must be >= 2.
- RANK_W, 16, rank width; ranks compare as unsigned, lower rank is served first.
- VALUE_W, 32, payload width.
- PUSHOUT, 0, 0 = stall pushes when full; 1 = when full, keep the DEPTH best entries and evict the worst one.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- push_valid  in  1  push request.
- push_ready  out  1  push accepted this cycle when push_valid && push_ready.
- push_rank  in  RANK_W  rank of the pushed element.
- push_value  in  VALUE_W  payload of the pushed element.
- pop_ready  in  1  consumer takes the head this cycle.
- pop_valid  out  1  head entry is valid (count != 0).
- pop_rank  out  RANK_W  rank of entry 0.
- pop_value  out  VALUE_W  payload of entry 0.
- count  out  $clog2(DEPTH+1)  current occupancy.
- evict_valid  out  1  registered one-cycle pulse: an element was discarded (PUSHOUT=1 only).
- evict_rank  out  RANK_W  rank of the discarded element.
- evict_value  out  VALUE_W  payload of the discarded element.

Behaviour:
- Reset (rst low, asynchronous): all entries invalid; count=0; pop_valid=0; evict_valid=0; evict_rank/value=0. push_ready=1 while in reset is don't-care; the first push is accepted on the first edge after rst releases.
- pop_fire = pop_valid && pop_ready. push_fire = push_valid && push_ready.
- pop_valid, pop_rank, pop_value are driven directly from entry 0 (no combinational path from push inputs).
- Latency: a pushed element is visible in the array, and at the head if it is the best, on the cycle after push_fire. There is no same-cycle bypass when empty.
- Insert position = number of valid entries with rank <= push_rank. The new element goes after all equal ranks (stable FIFO tie-break); entries at and beyond that position shift up by one.
- Pop: entry 0 is removed and entries 1..DEPTH-1 shift down; the top slot becomes invalid.
- Simultaneous push_fire and pop_fire: the insert position is computed against the pre-pop array, then the pop applies. If push_rank < the old head rank, the new element becomes the new head. count is unchanged.
- count update: +1 on push only; -1 on pop only; unchanged on both.
- PUSHOUT=0: push_ready = (count < DEPTH) || pop_ready. Full with pop_ready=1 accepts the push, since the pop frees a slot.
- PUSHOUT=1: push_ready is constant 1.
  - When full with no pop_fire: if push_rank < rank of entry DEPTH-1 (strictly), the new element is inserted, the old tail is evicted, and count stays DEPTH.
  - Otherwise the incoming element itself is evicted and the array is unchanged.
  - In either case, on the next cycle evict_valid=1 with the discarded element's rank and value for exactly one cycle.
- PUSHOUT=1, full with pop_fire: behaves as a normal push+pop; no eviction.
- Empty with pop_ready=1: no effect; pop_valid stays 0.
- Reset asserted mid-operation: state clears immediately regardless of in-flight handshakes. Elements pushed in that cycle are lost and are not reported as evicted.
- The array is never reordered except by push insertion, pop shift, or tail eviction.

Test Plan:
- Reset, then push ranks 5,2,9,2 (values A,B,C,D) on consecutive cycles, then pop 4 times -> pops emit B(2), D(2), A(5), C(9); count goes 0,1,2,3,4 then down to 0; pop_valid=0 afterwards.
- Empty: push rank 7 with pop_ready=1 in the same cycle -> nothing popped that cycle; next cycle pop_valid=1, pop_rank=7, count=1.
- Array holds ranks {3,8}; push rank 1 with pop_fire in the same cycle -> rank 3 popped; next cycle head rank=1, entry 1 rank=8, count=2.
- PUSHOUT=0, DEPTH=4, full with {1,2,3,4}: push rank 0 with pop_ready=0 -> push_ready=0 and the array is unchanged. Repeat with pop_ready=1 -> pops 1; array becomes {0,2,3,4}; count=4.
- PUSHOUT=1, DEPTH=4, full with {1,2,3,4}:
  - push rank 2 (value X) -> array {1,2,2(X),3}; next cycle evict_valid=1, evict_rank=4.
  - then push rank 9 (value Y) -> array unchanged; evict_valid=1, evict_rank=9, evict_value=Y.
- Push 3 entries, assert rst low between clock edges -> count=0 and pop_valid=0 immediately (asynchronous). After release, the first push of rank 6 appears at the head one cycle later.
